// File: rtl/capture_ctrl_pkg.sv
// capture_ctrl_pkg: shared types for the sample-memory acquisition controller.
//   cap_state_e : capture FSM states (also exported on the debug port)
//   SLOPE_*     : trig_slope encodings
package capture_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } cap_state_e;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: dual-port sample RAM bus between the capture controller
// (master) and the RAM (slave).
//   ram_addr_a/ram_we_a/ram_in_a : port A write address, enable, data
//   ram_addr_b                   : port B read address
//   ram_out_b                    : port B read data, registered inside the RAM
// Handshake: there is no backpressure on either port. A write is one cycle of
// ram_we_a high with ram_addr_a/ram_in_a stable in that cycle; the RAM takes it
// on the following edge. A read is fire-and-forget: ram_out_b holds the word
// at ram_addr_b one edge after ram_addr_b was presented.
interface capture_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] ram_addr_a;
  logic              ram_we_a;
  logic [DATA_W-1:0] ram_in_a;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_out_b;

  modport master (
    output ram_addr_a, ram_we_a, ram_in_a, ram_addr_b,
    input  ram_out_b
  );

  modport slave (
    input  ram_addr_a, ram_we_a, ram_in_a, ram_addr_b,
    output ram_out_b
  );
endinterface

// File: rtl/capture_ctrl_trig_detect.sv
// capture_ctrl_trig_detect: level/slope trigger comparator.
//   clock, reset_n          : clock, async active-low reset
//   sample_valid, sample    : incoming ADC sample
//   trig_level, trig_slope  : threshold and edge direction
//   clear                   : arm accepted; forget sample history
//   hit                     : sample crosses the level in the chosen direction
// hit is qualified by sample_valid and by having seen at least one earlier
// sample since the last clear; the caller restricts it to the ARMED phase.
module capture_ctrl_trig_detect
  import capture_ctrl_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              clear,
  output logic              hit
);
  logic [DATA_W-1:0] prev_q;
  logic              hist_q;
  logic              rise;
  logic              fall;

  // clear wins over a coincident sample: that sample is not part of the capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      hist_q <= 1'b0;
    end else if (clear) begin
      hist_q <= 1'b0;
    end else if (sample_valid) begin
      prev_q <= sample;
      hist_q <= 1'b1;
    end
  end

  assign rise = (prev_q < trig_level) && (sample >= trig_level);
  assign fall = (prev_q > trig_level) && (sample <= trig_level);
  assign hit  = sample_valid && hist_q && ((trig_slope == SLOPE_FALL) ? fall : rise);

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: oscilloscope acquisition controller. Writes samples into the
// sample RAM as a circular buffer, keeps pretrig samples before the trigger,
// freezes after the post-trigger window and serves oldest-first readout.
//   clock, reset_n            : clock, async active-low reset
//   sample_valid, sample      : ADC sample strobe and data
//   arm                       : start a capture (taken in IDLE/DONE only)
//   trig_level, trig_slope    : trigger threshold / direction
//   pretrig                   : pre-trigger sample count, latched on arm
//   force_trig                : sticky software trigger
//   rd_req, rd_index          : readout request, index 0 = oldest
//   rd_valid, rd_data         : readout result, two cycles after rd_req
//   busy, capture_done        : PREFILL/ARMED/POST, and DONE
//   trig_addr                 : RAM address of the trigger sample
//   state_dbg                 : current FSM state
//   ram                       : RAM port A (write) / port B (read)
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              force_trig,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_index,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr,
  output cap_state_e        state_dbg,
  capture_ctrl_if.master    ram
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  cap_state_e        state_q;
  logic [ADDR_W-1:0] wr_ptr_q, start_addr_q, cnt_q, pre_q, trig_addr_q;
  logic              force_q, busy_q, done_q;
  logic [ADDR_W-1:0] ram_addr_a_q, ram_addr_b_q;
  logic              ram_we_a_q;
  logic [DATA_W-1:0] ram_in_a_q;
  logic              rd_v1_q, rd_v2_q;

  logic              arm_take, capturing, write_en, armed_eval, hit, trig;
  logic [ADDR_W-1:0] cnt_inc, post_len;

  assign arm_take  = arm && ((state_q == IDLE) || (state_q == DONE));
  assign capturing = (state_q == PREFILL) || (state_q == ARMED) || (state_q == POST);
  assign write_en  = sample_valid && capturing;
  // With no pre-trigger samples the very first sample is already in the
  // trigger window, even though the FSM still sits in PREFILL.
  assign armed_eval = (state_q == ARMED) || ((state_q == PREFILL) && (pre_q == '0));
  assign trig       = sample_valid && armed_eval && (hit || force_q);
  assign cnt_inc    = cnt_q + 1'b1;
  assign post_len   = ADDR_MAX - pre_q;

  capture_ctrl_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .clear        (arm_take),
    .hit          (hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      start_addr_q <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      trig_addr_q  <= '0;
      force_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ram_addr_a_q <= '0;
      ram_we_a_q   <= 1'b0;
      ram_in_a_q   <= '0;
      ram_addr_b_q <= '0;
      rd_v1_q      <= 1'b0;
      rd_v2_q      <= 1'b0;
    end else begin
      ram_we_a_q <= write_en;
      if (write_en) begin
        ram_addr_a_q <= wr_ptr_q;
        ram_in_a_q   <= sample;
        wr_ptr_q     <= wr_ptr_q + 1'b1;
      end

      if (force_trig) force_q <= 1'b1;

      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            // pretrig is ADDR_W bits wide, so it never exceeds DEPTH-1
            pre_q   <= pretrig;
            cnt_q   <= '0;
            force_q <= 1'b0;
            state_q <= PREFILL;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        PREFILL, ARMED: begin
          if (trig) begin
            trig_addr_q  <= wr_ptr_q;
            start_addr_q <= wr_ptr_q - pre_q;
            cnt_q        <= '0;
            // a full-depth pre-trigger record is complete with the trigger sample
            if (pre_q == ADDR_MAX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= POST;
            end
          end else if ((state_q == PREFILL) && sample_valid) begin
            if (pre_q == '0) begin
              state_q <= ARMED;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc == pre_q) state_q <= ARMED;
            end
          end
        end
        POST: begin
          if (sample_valid) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == post_len) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (rd_req) ram_addr_b_q <= start_addr_q + rd_index;
      rd_v1_q <= rd_req;
      rd_v2_q <= rd_v1_q;
    end
  end

  assign ram.ram_addr_a = ram_addr_a_q;
  assign ram.ram_we_a   = ram_we_a_q;
  assign ram.ram_in_a   = ram_in_a_q;
  assign ram.ram_addr_b = ram_addr_b_q;
  assign rd_valid       = rd_v2_q;
  assign rd_data        = ram.ram_out_b;
  assign busy           = busy_q;
  assign capture_done   = done_q;
  assign trig_addr      = trig_addr_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: bench for capture_ctrl at ADDR_W=4 (DEPTH=16), DATA_W=12.
// The reference model works on the list of samples fed since arm: it finds the
// trigger index from the crossing rules, and the expected record is simply the
// 16-sample slice ending DEPTH-1-pre samples after the trigger.
module tb_capture_ctrl;
  import capture_ctrl_pkg::*;

  localparam int AW = 4;
  localparam int DW = 12;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          arm = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_slope = 1'b0;
  logic [AW-1:0] pretrig = '0;
  logic          force_trig = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_index = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          capture_done;
  logic [AW-1:0] trig_addr;
  cap_state_e    state_dbg;

  capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_bus ();

  capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .arm          (arm),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .pretrig      (pretrig),
    .force_trig   (force_trig),
    .rd_req       (rd_req),
    .rd_index     (rd_index),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .busy         (busy),
    .capture_done (capture_done),
    .trig_addr    (trig_addr),
    .state_dbg    (state_dbg),
    .ram          (ram_bus)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clock = ~clock;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_bus.ram_we_a === 1'b1) mem[ram_bus.ram_addr_a] <= ram_bus.ram_in_a;
    ram_bus.ram_out_b <= mem[ram_bus.ram_addr_b];
  end

  int we_cnt = 0;
  always @(posedge clock) if (ram_bus.ram_we_a === 1'b1) we_cnt++;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int m_wr_ptr = 0;
  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] exp_q[$];

  function automatic bit crossed(input logic [DW-1:0] prev, input logic [DW-1:0] cur,
                                 input logic [DW-1:0] level, input logic slope);
    if (slope == SLOPE_RISE) return (prev < level) && (cur >= level);
    return (prev > level) && (cur <= level);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic read_record(input string name);
    int got;
    got = 0;
    for (int c = 0; c < DEPTH + 3; c++) begin
      rd_req   = (c < DEPTH);
      rd_index = AW'(c);
      tick();
      if (rd_valid === 1'b1) begin
        logic [DW-1:0] e;
        got++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s_rd_extra: rd_valid with nothing expected, data=%0d", name, rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            bad++;
            $display("FAIL %s_rd_data[%0d]: got %0d expected %0d", name, got - 1, rd_data, e);
          end
        end
      end
    end
    rd_req = 1'b0;
    total++;
    if (got != DEPTH) begin
      bad++;
      $display("FAIL %s_rd_count: got %0d expected %0d", name, got, DEPTH);
    end
    exp_q.delete();
  endtask

  // Arms, feeds stim_q (gap idle cycles before each sample), checks busy/done
  // after every sample, then checks write count, trig_addr and the record.
  task automatic run_capture(input int pre_req, input logic [DW-1:0] level, input logic slope,
                             input int force_at, input int arm_at, input int gap, input string name);
    int pre, base, trig_idx, n_written, we_start;
    bit force_pend, done;
    pre = (pre_req > DEPTH - 1) ? DEPTH - 1 : pre_req;
    trig_level = level;
    trig_slope = slope;
    pretrig    = AW'(pre);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    total++;
    if ({busy, capture_done} !== 2'b10) begin
      bad++;
      $display("FAIL %s_arm: busy/done=%b%b expected 10", name, busy, capture_done);
    end
    base = m_wr_ptr;
    we_start = we_cnt;
    trig_idx = -1;
    n_written = 0;
    force_pend = 0;
    done = 0;
    for (int k = 0; k < stim_q.size() && !done; k++) begin
      if (k == force_at) begin
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        force_pend = 1;
      end
      if (k == arm_at) begin
        arm = 1'b1;
        pretrig = AW'(2);
        tick();
        arm = 1'b0;
        total++;
        if (state_dbg !== ARMED) begin
          bad++;
          $display("FAIL %s_arm_ignored: state=%0d expected %0d", name, state_dbg, ARMED);
        end
      end
      repeat (gap) tick();
      sample_valid = 1'b1;
      sample = stim_q[k];
      tick();
      sample_valid = 1'b0;
      n_written++;
      m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
      if (trig_idx < 0 && k >= pre)
        if (force_pend || (k > 0 && crossed(stim_q[k-1], stim_q[k], level, slope))) trig_idx = k;
      if (trig_idx >= 0 && k == trig_idx + (DEPTH - 1 - pre)) done = 1;
      total++;
      if ({busy, capture_done} !== {!done, done}) begin
        bad++;
        $display("FAIL %s_status@%0d: busy/done=%b%b expected %b%b", name, k, busy, capture_done,
                 !done, done);
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_complete: model record not finished after %0d samples", name, n_written);
      return;
    end
    // samples offered in DONE must not be written
    repeat (3) begin
      sample_valid = 1'b1;
      sample = 12'hABC;
      tick();
    end
    sample_valid = 1'b0;
    tick();
    tick();
    total++;
    if (we_cnt - we_start != n_written) begin
      bad++;
      $display("FAIL %s_writes: got %0d expected %0d", name, we_cnt - we_start, n_written);
    end
    total++;
    if (trig_addr !== AW'((base + trig_idx) % DEPTH)) begin
      bad++;
      $display("FAIL %s_trig_addr: got %0d expected %0d", name, trig_addr, (base + trig_idx) % DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(stim_q[trig_idx - pre + i]);
    read_record(name);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({ram_bus.ram_addr_a, ram_bus.ram_we_a, ram_bus.ram_in_a, ram_bus.ram_addr_b} !== '0) begin
      bad++;
      $display("FAIL reset_ram: addr_a=%0d we=%b in=%0d addr_b=%0d expected all 0", ram_bus.ram_addr_a,
               ram_bus.ram_we_a, ram_bus.ram_in_a, ram_bus.ram_addr_b);
    end
    total++;
    if ({rd_valid, busy, capture_done, trig_addr} !== '0) begin
      bad++;
      $display("FAIL reset_status: rd_valid=%b busy=%b done=%b trig_addr=%0d expected all 0",
               rd_valid, busy, capture_done, trig_addr);
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (state_dbg !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
    end
    m_wr_ptr = 0;
  endtask

  task automatic test_pretrig_ramp();
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back(DW'(i));
    run_capture(4, 12'd20, SLOPE_RISE, -1, -1, 0, "ramp");
  endtask

  task automatic test_falling();
    stim_q.delete();
    for (int i = 0; i < 30; i++) stim_q.push_back(DW'(100 - 10 * i));
    run_capture(0, 12'd85, SLOPE_FALL, -1, -1, 0, "falling");
  endtask

  task automatic test_first_sample();
    stim_q.delete();
    for (int i = 0; i < 30; i++) stim_q.push_back(DW'(60 + 10 * i));
    run_capture(0, 12'd50, SLOPE_RISE, 3, -1, 0, "first_force");
  endtask

  task automatic test_clamp_ignore();
    stim_q.delete();
    for (int i = 1; i <= 15; i++) stim_q.push_back(DW'(i));
    stim_q.push_back(12'd50);
    stim_q.push_back(12'd200);
    for (int i = 0; i < 5; i++) stim_q.push_back(12'd300);
    run_capture(15, 12'd100, SLOPE_RISE, -1, 16, 0, "clamp");
  endtask

  task automatic test_gapped();
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back(DW'(i));
    run_capture(6, 12'd10, SLOPE_RISE, -1, -1, 2, "gapped");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      logic [DW-1:0] lvl;
      lvl = DW'($urandom_range(200, 3800));
      stim_q.delete();
      for (int i = 0; i < 60; i++) stim_q.push_back(DW'($urandom_range(lvl - 150, lvl + 150)));
      run_capture($urandom_range(0, 15), lvl, 1'($urandom_range(0, 1)), $urandom_range(20, 40), -1,
                  $urandom_range(0, 1), "random");
    end
  endtask

  task automatic test_reset_mid_post();
    trig_level = 12'd5;
    trig_slope = SLOPE_RISE;
    pretrig = AW'(2);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      sample_valid = 1'b1;
      sample = DW'(i);
      tick();
    end
    sample_valid = 1'b0;
    total++;
    if ({busy, ram_bus.ram_we_a, state_dbg} !== {2'b11, POST}) begin
      bad++;
      $display("FAIL midpost_pre: busy=%b we=%b state=%0d expected 1 1 %0d", busy, ram_bus.ram_we_a,
               state_dbg, POST);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({busy, ram_bus.ram_we_a, capture_done} !== 3'b000) begin
      bad++;
      $display("FAIL midpost_reset: busy=%b we=%b done=%b expected 000", busy, ram_bus.ram_we_a,
               capture_done);
    end
    tick();
    reset_n = 1'b1;
    m_wr_ptr = 0;
    tick();
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back(DW'(500 + 3 * i));
    run_capture(5, 12'd530, SLOPE_RISE, -1, -1, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_pretrig_ramp();
    test_falling();
    test_first_sample();
    test_clamp_ignore();
    test_gapped();
    test_random();
    test_reset_mid_post();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
